// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: bus port numbers, vector
// table base, service-state encoding, nesting depth and the priority encoder.
package interrupt_controller_pkg;

    localparam logic [15:0] VEC_BASE     = 16'hFFF0;
    localparam logic [3:0]  PORT_MASK    = 4'hC;
    localparam logic [3:0]  PORT_PEND    = 4'hD;
    localparam int          NEST_DEPTH   = 4;
    // Vector index reported when nothing unmasked is pending
    localparam logic [3:0]  VEC_SPURIOUS = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } ic_state_e;

    // Index of the lowest set bit (bit 0 wins), or VEC_SPURIOUS when empty
    function automatic logic [3:0] lowest_set(input logic [7:0] vec);
        logic [3:0] idx;
        idx = VEC_SPURIOUS;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/interrupt_controller_irq_sync_edge.sv
// irq_sync_edge: one request line through a 2-flop synchronizer followed by a
// rising-edge detector. A short warm-up after reset keeps a level that was
// already high at reset release from being reported as a fresh edge.
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_in,
    output logic rise_s
);

    logic       sync1_r;
    logic       sync2_r;
    logic       prev_r;
    logic [2:0] warm_r;

    // Synchronizer stages, level history and warm-up tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            warm_r  <= 3'b000;
        end else begin
            sync1_r <= irq_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            warm_r  <= {warm_r[1:0], 1'b1};
        end
    end

    // Edge is only trusted once prev_r holds a genuinely sampled level
    assign rise_s = sync2_r & ~prev_r & warm_r[2];

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: eight edge-triggered request lines with bit-0-first
// priority, a mask register, and a return-address/vector handshake with the
// control unit over the shared 16-bit d_bus.
// Build option: define INT_NEST_EN to turn the single return-address slot into
// a NEST_DEPTH-deep LIFO with preemption by higher-priority requests and a
// sticky overflow flag in bit 15 of the pending port.
module interrupt_controller
    import interrupt_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  irq,
    output logic        io_interrupt,
    input  logic        io_store_retaddr,
    input  logic        io_push_int_addr,
    input  logic        io_push_retaddr,
    input  logic        io_push_ints,
    input  logic [3:0]  io_addr,
    input  logic        io_addr_read,
    input  logic        io_write,
    input  logic        io_push,
    inout  wire  [15:0] d_bus
);

    logic [7:0]  rise_s;
    logic [7:0]  pending_r;
    logic [7:0]  pending_nxt_s;
    logic [7:0]  mask_r;
    logic [7:0]  mask_nxt_s;
    ic_state_e   state_r;
    ic_state_e   state_nxt_s;
    logic [7:0]  cand_s;
    logic [7:0]  clr_store_s;
    logic [7:0]  clr_w1c_s;
    logic [3:0]  win_idx_s;
    logic        win_hit_s;
    logic        wr_mask_s;
    logic        wr_pend_s;
    logic        rd_mask_s;
    logic        rd_pend_s;
    logic        store_ok_s;
    logic        last_entry_s;
    logic [15:0] top_ret_s;
    logic [3:0]  top_vec_s;
    logic        ovf_s;
    logic        int_nxt_s;
    logic        drv_en_s;
    logic [15:0] drv_val_s;

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_sync
            irq_sync_edge u_sync (
                .clk    (clk),
                .rst_n  (rst_n),
                .irq_in (irq[g]),
                .rise_s (rise_s[g])
            );
        end
    endgenerate

    assign wr_mask_s = io_write & io_addr_read & (io_addr == PORT_MASK);
    assign wr_pend_s = io_write & io_addr_read & (io_addr == PORT_PEND);
    assign rd_mask_s = io_push  & io_addr_read & (io_addr == PORT_MASK);
    assign rd_pend_s = io_push  & io_addr_read & (io_addr == PORT_PEND);

    assign cand_s    = pending_r & mask_r;
    assign win_idx_s = lowest_set(cand_s);
    assign win_hit_s = |cand_s;

`ifdef INT_NEST_EN
    logic [15:0] ret_stk_r [NEST_DEPTH];
    logic [3:0]  vec_stk_r [NEST_DEPTH];
    logic [2:0]  depth_r;
    logic        ovf_r;
    logic        pop_s;
    logic [1:0]  top_idx_s;
    logic [3:0]  top_vec_nxt_s;
    logic [3:0]  nxt_win_s;

    assign store_ok_s   = io_store_retaddr & (depth_r != 3'(NEST_DEPTH));
    assign pop_s        = io_push_retaddr & (depth_r != 3'd0);
    assign last_entry_s = (depth_r <= 3'd1);
    assign top_idx_s    = (depth_r == 3'd0) ? 2'd0 : 2'(depth_r - 3'd1);
    assign top_ret_s    = ret_stk_r[top_idx_s];
    assign top_vec_s    = vec_stk_r[top_idx_s];
    assign ovf_s        = ovf_r;
    assign nxt_win_s    = lowest_set(pending_nxt_s & mask_nxt_s);

    // Vector being serviced once this cycle's push or pop has taken effect
    always_comb begin
        top_vec_nxt_s = top_vec_s;
        if (store_ok_s) begin
            top_vec_nxt_s = win_idx_s;
        end else if (pop_s && (depth_r >= 3'd2)) begin
            top_vec_nxt_s = vec_stk_r[2'(depth_r - 3'd2)];
        end else begin
            top_vec_nxt_s = top_vec_s;
        end
    end

    // Request when idle, or when something outranks the vector in service
    always_comb begin
        int_nxt_s = 1'b0;
        if (state_nxt_s == ST_IDLE) begin
            int_nxt_s = |(pending_nxt_s & mask_nxt_s);
        end else begin
            int_nxt_s = (nxt_win_s < top_vec_nxt_s);
        end
    end

    // Return-address/vector LIFO and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                ret_stk_r[i] <= 16'h0000;
                vec_stk_r[i] <= 4'd0;
            end
            depth_r <= 3'd0;
            ovf_r   <= 1'b0;
        end else begin
            if (store_ok_s) begin
                ret_stk_r[depth_r[1:0]] <= d_bus;
                vec_stk_r[depth_r[1:0]] <= win_idx_s;
                depth_r                 <= depth_r + 3'd1;
            end else if (pop_s) begin
                depth_r <= depth_r - 3'd1;
            end else begin
                depth_r <= depth_r;
            end
            if (io_store_retaddr && !store_ok_s) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end
`else
    logic [15:0] retaddr_r;
    logic [3:0]  vec_idx_r;

    assign store_ok_s   = io_store_retaddr;
    assign last_entry_s = 1'b1;
    assign top_ret_s    = retaddr_r;
    assign top_vec_s    = vec_idx_r;
    assign ovf_s        = 1'b0;

    // Without nesting a request is only raised while idle
    always_comb begin
        int_nxt_s = 1'b0;
        if (state_nxt_s == ST_IDLE) begin
            int_nxt_s = |(pending_nxt_s & mask_nxt_s);
        end else begin
            int_nxt_s = 1'b0;
        end
    end

    // Single return-address slot and the vector chosen at acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retaddr_r <= 16'h0000;
            vec_idx_r <= 4'd0;
        end else if (store_ok_s) begin
            retaddr_r <= d_bus;
            vec_idx_r <= win_idx_s;
        end else begin
            retaddr_r <= retaddr_r;
            vec_idx_r <= vec_idx_r;
        end
    end
`endif

    // Pending clear sources (acknowledge and write-1-to-clear); new edges win
    always_comb begin
        if (store_ok_s && win_hit_s) begin
            clr_store_s = 8'(8'h01 << win_idx_s);
        end else begin
            clr_store_s = 8'h00;
        end
        if (wr_pend_s) begin
            clr_w1c_s = d_bus[7:0];
        end else begin
            clr_w1c_s = 8'h00;
        end
        pending_nxt_s = (pending_r & ~clr_store_s & ~clr_w1c_s) | rise_s;
        if (wr_mask_s) begin
            mask_nxt_s = d_bus[7:0];
        end else begin
            mask_nxt_s = mask_r;
        end
    end

    // Service state: acknowledge enters service, return leaves it
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (store_ok_s) begin
                    state_nxt_s = ST_SERVICE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (store_ok_s) begin
                    state_nxt_s = ST_SERVICE;
                end else if (io_push_retaddr && last_entry_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SERVICE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Pending, mask, service state and the registered interrupt request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r    <= 8'h00;
            mask_r       <= 8'h00;
            state_r      <= ST_IDLE;
            io_interrupt <= 1'b0;
        end else begin
            pending_r    <= pending_nxt_s;
            mask_r       <= mask_nxt_s;
            state_r      <= state_nxt_s;
            io_interrupt <= int_nxt_s;
        end
    end

    // Single bus driver selected by fixed strobe priority
    always_comb begin
        drv_en_s  = 1'b1;
        drv_val_s = 16'h0000;
        if (io_push_int_addr) begin
            drv_val_s = VEC_BASE + {12'h000, top_vec_s};
        end else if (io_push_retaddr) begin
            drv_val_s = top_ret_s;
        end else if (io_push_ints) begin
            drv_val_s = {pending_r, mask_r};
        end else if (rd_mask_s) begin
            drv_val_s = {8'h00, mask_r};
        end else if (rd_pend_s) begin
            drv_val_s = {ovf_s, 7'h00, pending_r};
        end else begin
            drv_en_s = 1'b0;
        end
    end

    // The bus is released whenever reset is asserted
    assign d_bus = (drv_en_s && rst_n) ? drv_val_s : {16{1'bz}};

endmodule
